// File: rtl/vga_sprite_compositor_if.sv
// Pixel-path bus between the game logic / VGA timing side and the sprite
// compositor.
//   master : drives frame_start, x, y, char_x_pos, char_y_pos, char_state,
//            hit_pulse; receives pixel_color, owner_onehot, collision.
//   slave  : the compositor side (mirror of master).
interface vga_sprite_compositor_if #(
    parameter int NUM_CHARS = 2,
    parameter int COORD_W   = 10
);
    logic                           frame_start;
    logic [COORD_W-1:0]             x;
    logic [COORD_W-1:0]             y;
    logic [NUM_CHARS*COORD_W-1:0]   char_x_pos;
    logic [NUM_CHARS*COORD_W-1:0]   char_y_pos;
    logic [NUM_CHARS*4-1:0]         char_state;
    logic [NUM_CHARS-1:0]           hit_pulse;
    logic [7:0]                     pixel_color;
    logic [NUM_CHARS-1:0]           owner_onehot;
    logic                           collision;

    modport master (
        output frame_start, x, y, char_x_pos, char_y_pos, char_state, hit_pulse,
        input  pixel_color, owner_onehot, collision
    );

    modport slave (
        input  frame_start, x, y, char_x_pos, char_y_pos, char_state, hit_pulse,
        output pixel_color, owner_onehot, collision
    );
endinterface

// File: rtl/vga_sprite_compositor.sv
// Composites NUM_CHARS rectangular character sprites over a solid background,
// index 0 on top. Sprite positions/states are latched once per frame into
// shadow registers so a sprite never tears mid-frame. Each character has an
// 8-bit hit-flash timer, and a sticky overlap detector reports per frame
// whether any two sprites overlapped.
// Ports:
//   vga_clk : pixel clock (only clock)
//   rst     : synchronous active-high reset
//   bus     : slave side of vga_sprite_compositor_if
//             (frame_start, x, y, char_*_pos, char_state, hit_pulse in;
//              pixel_color, owner_onehot, collision out)
// Latency: x/y to pixel_color/owner_onehot is two register stages.
module vga_sprite_compositor #(
    parameter int         NUM_CHARS    = 2,
    parameter int         CHAR_WIDTH   = 128,
    parameter int         CHAR_HEIGHT  = 240,
    parameter int         COORD_W      = 10,
    parameter logic [7:0] BG_COLOR     = 8'b111_111_11,
    parameter int         FLASH_FRAMES = 8
) (
    input logic                    vga_clk,
    input logic                    rst,
    vga_sprite_compositor_if.slave bus
);

    // One extra bit so position + size never wraps; sprites clip at the edge.
    localparam logic [COORD_W:0] CW_EXT     = (COORD_W+1)'(CHAR_WIDTH);
    localparam logic [COORD_W:0] CH_EXT     = (COORD_W+1)'(CHAR_HEIGHT);
    localparam logic [7:0]       FLASH_LOAD = 8'(FLASH_FRAMES);

    function automatic logic [7:0] state_color(input logic [3:0] s);
        logic [7:0] c;
        case (s)
            4'd0, 4'd1, 4'd2: c = 8'b000_000_00;
            4'd3:             c = 8'b000_111_00;
            4'd4:             c = 8'b111_000_00;
            4'd5:             c = 8'b111_111_00;
            4'd6:             c = 8'b000_111_11;
            4'd7:             c = 8'b111_000_11;
            4'd8:             c = 8'b111_111_00;
            default:          c = 8'b000_000_01;
        endcase
        return c;
    endfunction

    // Per-frame shadow state and flash timers
    logic [COORD_W-1:0] sx_q    [NUM_CHARS];
    logic [COORD_W-1:0] sy_q    [NUM_CHARS];
    logic [3:0]         st_q    [NUM_CHARS];
    logic [7:0]         flash_q [NUM_CHARS];
    logic [NUM_CHARS-1:0] en_q;

    // Stage-1 inputs (combinational from current pixel and shadow state)
    logic [COORD_W:0]     x_ext;
    logic [COORD_W:0]     y_ext;
    logic [NUM_CHARS-1:0] cover_d;
    logic [7:0]           color_d [NUM_CHARS];
    logic                 overlap_d;

    // Stage-1 registers
    logic [NUM_CHARS-1:0] cover_p1_q;
    logic [7:0]           color_p1_q [NUM_CHARS];

    // Stage-2 inputs / registers
    logic [7:0]           pix_d;
    logic [NUM_CHARS-1:0] owner_d;
    logic [7:0]           pixel_color_q;
    logic [NUM_CHARS-1:0] owner_q;

    logic collision_q;
    logic overlap_acc_q;

    assign x_ext = {1'b0, bus.x};
    assign y_ext = {1'b0, bus.y};

    always_comb begin
        for (int i = 0; i < NUM_CHARS; i++) begin
            cover_d[i] = en_q[i]
                      && (x_ext >= {1'b0, sx_q[i]}) && (x_ext < ({1'b0, sx_q[i]} + CW_EXT))
                      && (y_ext >= {1'b0, sy_q[i]}) && (y_ext < ({1'b0, sy_q[i]} + CH_EXT));
            color_d[i] = state_color(st_q[i]);
            // Odd, nonzero flash count blinks the sprite to its inverse colour.
            if ((flash_q[i] != 8'd0) && flash_q[i][0]) begin
                color_d[i] = ~color_d[i];
            end
        end
        overlap_d = ($countones(cover_d) > 1);
    end

    // Lowest covering index wins: walk from the top index down.
    always_comb begin
        pix_d   = BG_COLOR;
        owner_d = '0;
        for (int i = NUM_CHARS-1; i >= 0; i--) begin
            if (cover_p1_q[i]) begin
                pix_d      = color_p1_q[i];
                owner_d    = '0;
                owner_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                sx_q[i]       <= '0;
                sy_q[i]       <= '0;
                st_q[i]       <= '0;
                flash_q[i]    <= '0;
                color_p1_q[i] <= '0;
            end
            en_q          <= '0;
            cover_p1_q    <= '0;
            pixel_color_q <= '0;
            owner_q       <= '0;
            collision_q   <= 1'b0;
            overlap_acc_q <= 1'b0;
        end else begin
            // Frame boundary: latch shadows and publish last frame's overlap
            if (bus.frame_start) begin
                for (int i = 0; i < NUM_CHARS; i++) begin
                    sx_q[i] <= bus.char_x_pos[i*COORD_W +: COORD_W];
                    sy_q[i] <= bus.char_y_pos[i*COORD_W +: COORD_W];
                    st_q[i] <= bus.char_state[i*4 +: 4];
                end
                en_q          <= '1;
                collision_q   <= overlap_acc_q | overlap_d;
                overlap_acc_q <= 1'b0;
            end else if (overlap_d) begin
                overlap_acc_q <= 1'b1;
            end

            // A hit reload takes precedence over the per-frame decrement.
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (bus.hit_pulse[i]) begin
                    flash_q[i] <= FLASH_LOAD;
                end else if (bus.frame_start && (flash_q[i] != 8'd0)) begin
                    flash_q[i] <= flash_q[i] - 8'd1;
                end
            end

            // Stage 1: cover flags and post-flash colours
            cover_p1_q <= cover_d;
            for (int i = 0; i < NUM_CHARS; i++) begin
                color_p1_q[i] <= color_d[i];
            end

            // Stage 2: priority-resolved pixel
            pixel_color_q <= pix_d;
            owner_q       <= owner_d;
        end
    end

    assign bus.pixel_color  = pixel_color_q;
    assign bus.owner_onehot = owner_q;
    assign bus.collision    = collision_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor (NUM_CHARS=2, defaults elsewhere).
module tb_vga_sprite_compositor;

    localparam logic [7:0] BG   = 8'hFF;
    localparam logic [7:0] RED  = 8'b111_000_00;
    localparam logic [7:0] GRN  = 8'b000_111_00;
    localparam logic [7:0] IRED = 8'b000_111_11;

    logic vga_clk;
    logic rst;
    int   checks;
    int   failures;

    vga_sprite_compositor_if #(.NUM_CHARS(2), .COORD_W(10)) bus ();

    vga_sprite_compositor #(
        .NUM_CHARS   (2),
        .CHAR_WIDTH  (128),
        .CHAR_HEIGHT (240),
        .COORD_W     (10),
        .BG_COLOR    (8'b111_111_11),
        .FLASH_FRAMES(8)
    ) dut (
        .vga_clk(vga_clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic set_char(input int i, input int cx, input int cy, input int st);
        bus.char_x_pos[i*10 +: 10] = 10'(cx);
        bus.char_y_pos[i*10 +: 10] = 10'(cy);
        bus.char_state[i*4 +: 4]   = 4'(st);
    endtask

    task automatic fs(input logic [1:0] hit);
        bus.frame_start = 1'b1;
        bus.hit_pulse   = hit;
        tick();
        bus.frame_start = 1'b0;
        bus.hit_pulse   = 2'b00;
    endtask

    task automatic hit_only(input logic [1:0] hit);
        bus.hit_pulse = hit;
        tick();
        bus.hit_pulse = 2'b00;
    endtask

    // Drive a pixel and wait out the two pipeline stages.
    task automatic px(input int xx, input int yy);
        bus.x = 10'(xx);
        bus.y = 10'(yy);
        tick();
        tick();
    endtask

    task automatic chk_px(input string tag, input int xx, input int yy,
                          input logic [7:0] col, input logic [1:0] own);
        px(xx, yy);
        chk({tag, "_color"}, bus.pixel_color, col);
        chk({tag, "_owner"}, 8'(bus.owner_onehot), 8'(own));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        bus.char_x_pos  = '0;
        bus.char_y_pos  = '0;
        bus.char_state  = '0;
        bus.hit_pulse   = '0;
        tick();
        tick();
        chk("reset_color", bus.pixel_color, 8'h00);
        chk("reset_owner", 8'(bus.owner_onehot), 8'h00);
        chk("reset_coll", 8'(bus.collision), 8'h00);

        // Inputs present but no frame_start yet: background only
        rst = 1'b0;
        set_char(0, 100, 50, 0);
        set_char(1, 600, 400, 0);
        chk_px("pre_fs", 150, 60, BG, 2'b00);

        // Scan y=60, x=99..228 across char0 at (100,50) state 0
        fs(2'b00);
        bus.y = 10'd60;
        for (int k = 0; k <= 130; k++) begin
            if (k < 130) bus.x = 10'(99 + k);
            tick();
            if (k >= 1) begin
                if ((k - 1 == 0) || (k - 1 == 129)) begin
                    chk("scan_edge_color", bus.pixel_color, BG);
                    chk("scan_edge_owner", 8'(bus.owner_onehot), 8'h00);
                end else begin
                    chk("scan_in_color", bus.pixel_color, 8'h00);
                    chk("scan_in_owner", 8'(bus.owner_onehot), 8'h01);
                end
            end
        end

        // Priority and collision
        set_char(0, 100, 50, 4);
        set_char(1, 150, 60, 3);
        fs(2'b00);
        chk("coll_clean", 8'(bus.collision), 8'h00);
        chk_px("prio_both", 160, 70, RED, 2'b01);
        chk_px("prio_c1", 240, 70, GRN, 2'b10);
        set_char(1, 600, 400, 3);
        fs(2'b00);
        chk("coll_set", 8'(bus.collision), 8'h01);
        chk_px("separated", 160, 70, RED, 2'b01);
        fs(2'b00);
        chk("coll_clear", 8'(bus.collision), 8'h00);

        // Mid-frame position change is ignored until frame_start
        set_char(0, 300, 50, 4);
        chk_px("midframe_old", 160, 70, RED, 2'b01);
        fs(2'b00);
        chk_px("newpos_oldspot", 160, 70, BG, 2'b00);
        chk_px("newpos_new", 300, 70, RED, 2'b01);

        // Flash: hit coincident with frame_start loads 8 (even -> normal)
        set_char(0, 100, 50, 4);
        fs(2'b01);
        chk_px("flash8", 160, 70, RED, 2'b01);
        for (int f = 7; f >= 0; f--) begin
            fs(2'b00);
            px(160, 70);
            chk("flash_cnt", bus.pixel_color, (f % 2 == 1) ? IRED : RED);
        end
        fs(2'b00);
        chk_px("flash_done", 160, 70, RED, 2'b01);

        // Retrigger at count 3
        hit_only(2'b01);
        chk_px("hit8", 160, 70, RED, 2'b01);
        for (int f = 0; f < 5; f++) fs(2'b00);
        chk_px("flash3", 160, 70, IRED, 2'b01);
        hit_only(2'b01);
        chk_px("retrig8", 160, 70, RED, 2'b01);
        fs(2'b00);
        chk_px("retrig7", 160, 70, IRED, 2'b01);

        // Right-edge clipping; drain the flash counter (7 -> 0) meanwhile
        set_char(0, 1000, 50, 4);
        for (int f = 0; f < 7; f++) fs(2'b00);
        chk_px("clip_left", 1000, 70, RED, 2'b01);
        chk_px("clip_right", 1023, 70, RED, 2'b01);
        chk_px("clip_before", 999, 70, BG, 2'b00);
        chk_px("nowrap0", 0, 70, BG, 2'b00);
        chk_px("nowrap103", 103, 70, BG, 2'b00);

        // Reset mid-scan
        set_char(0, 100, 50, 4);
        set_char(1, 150, 60, 3);
        fs(2'b00);
        chk_px("pre_rst", 160, 70, RED, 2'b01);
        fs(2'b00);
        chk("pre_rst_coll", 8'(bus.collision), 8'h01);
        rst = 1'b1;
        tick();
        chk("rst_color", bus.pixel_color, 8'h00);
        chk("rst_owner", 8'(bus.owner_onehot), 8'h00);
        chk("rst_coll", 8'(bus.collision), 8'h00);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_bg", bus.pixel_color, BG);
        chk("post_rst_own", 8'(bus.owner_onehot), 8'h00);
        tick();
        tick();
        chk("post_rst_bg2", bus.pixel_color, BG);
        fs(2'b00);
        chk("post_rst_coll", 8'(bus.collision), 8'h00);
        chk_px("post_rst_fs", 160, 70, RED, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
